cnt_sched_arbiter: RTL

- Round-robin scheduler that shares one internal N-bit interval counter among R requesters.
- Each requester asks for a timed interval of `limit` count-enable ticks.
- The block grants one requester at a time, loads that requester's limit, clears and runs the counter, and pulses `done` to the winner on terminal count.
- Sits between several control FSMs needing delays/timeouts and the single shared timing resource.

---
 rtl/cnt_sched_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cnt_sched_arbiter.sv
// Round-robin arbiter sharing one N-bit interval counter among R requesters.
// The winner's limit is latched at grant; done pulses once the counter reaches it.
module cnt_sched_arbiter #(
    parameter  int N  = 12,
    parameter  int R  = 4,
    localparam int RW = $clog2(R)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [R-1:0]    req,
    input  logic [R*N-1:0]  limits,
    input  logic            tick,
    output logic            busy,
    output logic [R-1:0]    gnt,
    output logic [RW-1:0]   gnt_idx,
    output logic [R-1:0]    done,
    output logic [N-1:0]    cnt_val
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_cnt;
    logic [N-1:0]    r_lim;
    logic [RW-1:0]   r_ptr;
    logic [RW-1:0]   r_gnt_idx;
    logic [R-1:0]    r_gnt;
    logic [R-1:0]    r_done;

    logic            w_found;
    logic [RW-1:0]   w_sel;
    logic            w_term;
    logic            w_abort;
    logic [RW-1:0]   w_next_ptr;

    // Search ptr, ptr+1, ... mod R; the first active request wins.
    always_comb begin
        // NOTE: every output gets a default up front so no path can infer a latch.
        int j;
        j       = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < R; k++) begin
            j = (int'(r_ptr) + k) % R;
            if (!w_found && req[j]) begin
                w_found = 1'b1;
                w_sel   = RW'(j);
            end
        end
    end

    assign w_term     = (r_cnt == r_lim);
    assign w_abort    = !req[r_gnt_idx];
    assign w_next_ptr = (r_gnt_idx == RW'(R - 1)) ? '0 : r_gnt_idx + 1'b1;

    // NOTE: all state is updated with non-blocking assignments so every register
    // sees pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_lim     <= '0;
            r_ptr     <= '0;
            r_gnt_idx <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt_idx <= w_sel;
                        r_lim     <= limits[int'(w_sel)*N +: N];
                        r_gnt     <= R'(1) << w_sel;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_abort) begin
                        r_gnt   <= '0;
                        r_ptr   <= w_next_ptr;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Abort beats terminal count: a withdrawn request never sees done.
                    if (w_abort) begin
                        r_gnt   <= '0;
                        r_ptr   <= w_next_ptr;
                        r_state <= S_IDLE;
                    end else if (w_term) begin
                        r_done  <= R'(1) << r_gnt_idx;
                        r_state <= S_DONE;
                    end else if (tick) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_gnt   <= '0;
                    r_ptr   <= w_next_ptr;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign gnt     = r_gnt;
    assign gnt_idx = r_gnt_idx;
    assign done    = r_done;
    assign cnt_val = r_cnt;

endmodule
